// File: rtl/rgb_hsv_pkg.sv
// Shared types, constants and elaboration checks for the RGB-to-HSV stream converter.
package rgb_hsv_pkg;

    typedef enum logic [2:0] {IDLE, PREP, DIV, SCALE, OUT} state_t;
    typedef enum logic [1:0] {SEC_R, SEC_G, SEC_B} sector_t;

    localparam int DEG60  = 60;
    localparam int DEG360 = 360;
    localparam int OFF_R  = 0;
    localparam int OFF_G  = 2;
    localparam int OFF_B  = 4;

    function automatic int sec_offset(input sector_t sec);
        case (sec)
            SEC_G:   return OFF_G;
            SEC_B:   return OFF_B;
            default: return OFF_R;
        endcase
    endfunction

    // Output word must hold the hue (up to 360 -> 9 integer bits) and v = cmax << frac.
    function automatic bit width_ok(input int pix_w, input int frac, input int n);
        int wide;
        wide = (pix_w > 9) ? pix_w : 9;
        return n >= frac + wide + 1;
    endfunction

endpackage

// File: rtl/seq_frac_div.sv
// Iterative restoring divider for num <= den, producing QBITS quotient bits
// (one integer bit followed by QBITS-1 fraction bits), truncated.
module seq_frac_div #(
    parameter int W     = 8,
    parameter int QBITS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     num,
    input  logic [W-1:0]     den,
    output logic             busy,
    output logic             done,
    output logic [QBITS-1:0] quot
);

    localparam int CW = $clog2(QBITS + 1);

    logic [W:0]       r_rem;
    logic [W-1:0]     r_den;
    logic [QBITS-1:0] r_q;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_zero;
    logic             w_ge;
    logic [W:0]       w_diff;

    assign w_ge   = r_rem >= {1'b0, r_den};
    assign w_diff = r_rem - {1'b0, r_den};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_den  <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_zero <= 1'b0;
        end else if (start) begin
            r_rem  <= {1'b0, num};
            r_den  <= den;
            r_q    <= '0;
            r_cnt  <= CW'(QBITS);
            r_busy <= 1'b1;
            r_zero <= (den == '0);
        end else if (r_busy) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1))
                r_busy <= 1'b0;
            // A zero divisor still burns the full count so latency stays fixed.
            if (!r_zero) begin
                r_q   <= {r_q[QBITS-2:0], w_ge};
                r_rem <= w_ge ? (w_diff << 1) : (r_rem << 1);
            end
        end
    end

    assign busy = r_busy;
    assign done = r_busy && (r_cnt == CW'(1));
    assign quot = r_zero ? '0 : r_q;

endmodule

// File: rtl/rgb_hsv_stream.sv
// Handshaked RGB-to-HSV converter: one pixel in flight, two parallel fixed-point
// dividers for hue fraction and saturation, fixed latency.
module rgb_hsv_stream
    import rgb_hsv_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int FRAC  = 15,
    parameter int N     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] r,
    input  logic [PIX_W-1:0] g,
    input  logic [PIX_W-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     h,
    output logic [N-1:0]     s,
    output logic [N-1:0]     v
);

    generate
        if (!width_ok(PIX_W, FRAC, N)) begin : g_width_err
            $error("rgb_hsv_stream: N too small for PIX_W and FRAC");
        end
    endgenerate

    state_t              r_state;
    logic                r_in_ready, r_out_valid;
    logic [N-1:0]        r_h, r_s, r_v;
    logic [PIX_W-1:0]    r_r, r_g, r_b, r_cmax;
    logic                r_neg, r_dz;
    sector_t             r_sec;

    sector_t             w_sec;
    logic [PIX_W-1:0]    w_cmax, w_cmin, w_delta, w_mag;
    logic signed [PIX_W:0] w_num;
    logic                w_start, w_busy_h, w_busy_s, w_done_h, w_done_s;
    logic [FRAC:0]       w_quot_h, w_quot_s;
    logic signed [N:0]   w_qh, w_off, w_hq;
    logic signed [N+6:0] w_hq7, w_h60, w_hwrap;
    logic [N-1:0]        w_hue;

    function automatic logic signed [N+6:0] mul_deg60(input logic signed [N+6:0] x);
        logic signed [N+6:0] acc;
        acc = '0;
        for (int i = 0; i < 7; i++)
            if (DEG60[i]) acc = acc + (x <<< i);
        return acc;
    endfunction

    // Sector selection: ties resolve R, then G, then B.
    always_comb begin
        w_sec  = SEC_B;
        w_cmax = r_b;
        w_num  = {1'b0, r_r} - {1'b0, r_g};
        if (r_r >= r_g && r_r >= r_b) begin
            w_sec  = SEC_R;
            w_cmax = r_r;
            w_num  = {1'b0, r_g} - {1'b0, r_b};
        end else if (r_g >= r_b) begin
            w_sec  = SEC_G;
            w_cmax = r_g;
            w_num  = {1'b0, r_b} - {1'b0, r_r};
        end
        w_cmin = r_r;
        if (r_g < w_cmin) w_cmin = r_g;
        if (r_b < w_cmin) w_cmin = r_b;
        w_delta = w_cmax - w_cmin;
        w_mag   = w_num[PIX_W] ? PIX_W'(-w_num) : w_num[PIX_W-1:0];
    end

    assign w_start = (r_state == PREP);

    seq_frac_div #(.W(PIX_W), .QBITS(FRAC + 1)) div_h (
        .clk(clk), .rst(rst), .start(w_start), .num(w_mag), .den(w_delta),
        .busy(w_busy_h), .done(w_done_h), .quot(w_quot_h)
    );

    seq_frac_div #(.W(PIX_W), .QBITS(FRAC + 1)) div_s (
        .clk(clk), .rst(rst), .start(w_start), .num(w_delta), .den(w_cmax),
        .busy(w_busy_s), .done(w_done_s), .quot(w_quot_s)
    );

    // Hue: signed sector-relative quotient, scaled by 60 and wrapped into [0,360).
    always_comb begin
        w_qh  = {{(N - FRAC){1'b0}}, w_quot_h};
        w_off = '0;
        w_off[FRAC+2:FRAC] = 3'(sec_offset(r_sec));
        w_hq    = (r_neg ? -w_qh : w_qh) + w_off;
        w_hq7   = {{6{w_hq[N]}}, w_hq};
        w_h60   = mul_deg60(w_hq7);
        w_hwrap = w_h60;
        if (w_h60 < 0)
            w_hwrap = w_h60 + ((N+7)'(DEG360) <<< FRAC);
        w_hue = w_hwrap[N-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_h         <= '0;
            r_s         <= '0;
            r_v         <= '0;
            r_r         <= '0;
            r_g         <= '0;
            r_b         <= '0;
            r_cmax      <= '0;
            r_neg       <= 1'b0;
            r_dz        <= 1'b0;
            r_sec       <= SEC_R;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_r        <= r;
                        r_g        <= g;
                        r_b        <= b;
                        r_in_ready <= 1'b0;
                        r_state    <= PREP;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                PREP: begin
                    r_neg   <= w_num[PIX_W];
                    r_sec   <= w_sec;
                    r_cmax  <= w_cmax;
                    r_dz    <= (w_delta == '0);
                    r_state <= DIV;
                end
                DIV: begin
                    if (w_done_h && w_done_s)
                        r_state <= SCALE;
                    else if (!w_busy_h && !w_busy_s)
                        r_state <= IDLE;
                end
                SCALE: begin
                    r_h         <= r_dz ? '0 : w_hue;
                    r_s         <= (r_cmax == '0) ? '0 : {{(N - FRAC - 1){1'b0}}, w_quot_s};
                    r_v         <= {{(N - PIX_W - FRAC){1'b0}}, r_cmax, {FRAC{1'b0}}};
                    r_out_valid <= 1'b1;
                    r_state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign h         = r_h;
    assign s         = r_s;
    assign v         = r_v;

endmodule

// File: tb/tb_rgb_hsv_stream.sv
// Bench for rgb_hsv_stream: directed and random pixels on the default build and a
// PIX_W=10/FRAC=12/N=24 build, checked against an integer-arithmetic HSV model.
module tb_rgb_hsv_stream;

    logic        clk;
    logic        rst;
    logic        in_valid, out_ready;
    logic [7:0]  r, g, b;
    logic        in_ready, out_valid;
    logic [31:0] h, s, v;

    logic        in_valid2, out_ready2;
    logic [9:0]  r2, g2, b2;
    logic        in_ready2, out_valid2;
    logic [23:0] h2, s2, v2;

    int total = 0;
    int bad   = 0;

    rgb_hsv_stream #(.PIX_W(8), .FRAC(15), .N(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .r(r), .g(g), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .h(h), .s(s), .v(v)
    );

    rgb_hsv_stream #(.PIX_W(10), .FRAC(12), .N(24)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .r(r2), .g(g2), .b(b2), .out_valid(out_valid2), .out_ready(out_ready2),
        .h(h2), .s(s2), .v(v2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // HSV straight from the definition: integer division, multiply by 60, wrap.
    function automatic void model(input int fr, input int nw, input int pr, input int pg,
                                  input int pb, output longint eh, output longint es,
                                  output longint ev);
        int mx, mn, num, off, dl;
        longint qh, hq, hh;
        mx = pr; if (pg > mx) mx = pg; if (pb > mx) mx = pb;
        mn = pr; if (pg < mn) mn = pg; if (pb < mn) mn = pb;
        if (pr >= pg && pr >= pb) begin num = pg - pb; off = 0; end
        else if (pg >= pb)        begin num = pb - pr; off = 2; end
        else                      begin num = pr - pg; off = 4; end
        dl = mx - mn;
        qh = (dl == 0) ? 0 : (longint'(num < 0 ? -num : num) << fr) / dl;
        hq = (num < 0 ? -qh : qh) + (longint'(off) << fr);
        hh = 60 * hq;
        if (hh < 0) hh = hh + (longint'(360) << fr);
        eh = (dl == 0) ? 0 : hh % (longint'(1) << nw);
        es = (mx == 0) ? 0 : (longint'(dl) << fr) / mx;
        ev = longint'(mx) << fr;
    endfunction

    task automatic send(input int pr, input int pg, input int pb, input int hold);
        longint eh, es, ev;
        int n, viol;
        logic [31:0] h0, s0, v0;
        model(15, 32, pr, pg, pb, eh, es, ev);
        n = 0;
        while (!in_ready && n < 60) begin @(posedge clk); #1; n++; end
        check("in_ready_before_accept", in_ready, 1'b1);
        in_valid = 1'b1; r = 8'(pr); g = 8'(pg); b = 8'(pb);
        @(posedge clk); #1;
        in_valid = 1'b0; r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
        n = 1; viol = 0;
        while (!out_valid && n < 60) begin
            if (in_ready) viol++;
            @(posedge clk); #1; n++;
        end
        check("latency_edges", n, 19);
        check("in_ready_low_while_busy", viol, 0);
        check("h", h, eh);
        check("s", s, es);
        check("v", v, ev);
        h0 = h; s0 = s; v0 = v; viol = 0;
        repeat (hold) begin
            @(posedge clk); #1;
            if (!out_valid || in_ready || h !== h0 || s !== s0 || v !== v0) viol++;
        end
        if (hold > 0) check("hold_stable", viol, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 1'b0);
        check("in_ready_after_handshake", in_ready, 1'b1);
    endtask

    task automatic send2(input int pr, input int pg, input int pb);
        longint eh, es, ev;
        int n;
        model(12, 24, pr, pg, pb, eh, es, ev);
        n = 0;
        while (!in_ready2 && n < 60) begin @(posedge clk); #1; n++; end
        check("w10_in_ready", in_ready2, 1'b1);
        in_valid2 = 1'b1; r2 = 10'(pr); g2 = 10'(pg); b2 = 10'(pb);
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        n = 1;
        while (!out_valid2 && n < 60) begin @(posedge clk); #1; n++; end
        check("w10_latency_edges", n, 16);
        check("w10_h", h2, eh);
        check("w10_s", s2, es);
        check("w10_v", v2, ev);
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        out_ready2 = 1'b0;
        check("w10_out_valid_drop", out_valid2, 1'b0);
    endtask

    initial begin
        int stale;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; r = '0; g = '0; b = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; r2 = '0; g2 = '0; b2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_h", h, 0);
        check("rst_s", s, 0);
        check("rst_v", v, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("in_ready_after_rst", in_ready, 1'b1);

        send(255, 0, 0, 0);
        check("red_h_const", h, 0);
        send(0, 255, 0, 0);
        send(0, 0, 255, 0);
        send(255, 0, 255, 0);
        send(255, 255, 0, 0);
        send(128, 128, 128, 0);
        send(0, 0, 0, 0);
        send(0, 255, 0, 10);

        // Reset while the dividers are running: nothing may come out afterwards.
        in_valid = 1'b1; r = 8'd200; g = 8'd10; b = 8'd50;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b0);
        check("mid_rst_h", h, 0);
        check("mid_rst_s", s, 0);
        check("mid_rst_v", v, 0);
        rst = 1'b0;
        stale = 0;
        repeat (30) begin @(posedge clk); #1; if (out_valid) stale++; end
        check("no_stale_result", stale, 0);
        check("in_ready_after_mid_rst", in_ready, 1'b1);

        for (int k = 0; k < 20; k++) begin
            int pr, pg, pb;
            if (k % 2 == 0) begin
                pr = int'($urandom_range(0, 255));
                pg = int'($urandom_range(0, 255));
                pb = int'($urandom_range(0, 255));
            end else begin
                pr = 85 * int'($urandom_range(0, 3));
                pg = 85 * int'($urandom_range(0, 3));
                pb = 85 * int'($urandom_range(0, 3));
            end
            send(pr, pg, pb, int'($urandom_range(0, 3)));
        end

        send2(1023, 0, 0);
        send2(0, 1023, 512);
        for (int k = 0; k < 4; k++)
            send2(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                  int'($urandom_range(0, 1023)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
